prefetch_axi_issuer: RTL

AXI read initiator for the prefetcher. It accepts block-aligned prefetch addresses from the prefetch decision logic and issues them as INCR bursts on the AXI AR channel. It collects the R-channel beats into a full block. It drives the prefetch data queue's opcode port: writeReq (2) when an AR is accepted, writeResp (3) with the assembled block, and invalidate (0) when a response fails.

---
 rtl/prefetcher_pkg.sv | 16 +
 rtl/prefetch_addr_fifo.sv | 51 +++++
 rtl/prefetch_axi_issuer.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/prefetcher_pkg.sv
// Shared constants and types for the prefetcher AXI read path.
// Covers queue opcodes, AXI encodings and the AR channel state encoding.
package prefetcher_pkg;
    localparam logic [1:0] OP_INVALIDATE = 2'd0;
    localparam logic [1:0] OP_READ       = 2'd1;
    localparam logic [1:0] OP_WRITE_REQ  = 2'd2;
    localparam logic [1:0] OP_WRITE_RESP = 2'd3;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    typedef enum logic {
        AR_IDLE = 1'b0,
        AR_ADDR = 1'b1
    } ar_state_e;
endpackage

// File: rtl/prefetch_addr_fifo.sv
// Address FIFO holding the block address of every accepted AR, in issue order.
// The head is read combinationally so it is usable in the burst completion cycle.
module prefetch_addr_fifo #(
    parameter int WIDTH     = 64,
    parameter int LOG_DEPTH = 3
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int DEPTH = 1 << LOG_DEPTH;

    logic [WIDTH-1:0]   mem [DEPTH];
    logic [LOG_DEPTH:0] wr_ptr_q, wr_ptr_d;
    logic [LOG_DEPTH:0] rd_ptr_q, rd_ptr_d;
    logic               do_push, do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[LOG_DEPTH] != rd_ptr_q[LOG_DEPTH]) &&
                   (wr_ptr_q[LOG_DEPTH-1:0] == rd_ptr_q[LOG_DEPTH-1:0]);
    // A pop frees the slot in the same cycle, so push is legal when full and popping.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr_q[LOG_DEPTH-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q[LOG_DEPTH-1:0]] <= push_data;
    end
endmodule

// File: rtl/prefetch_axi_issuer.sv
// Issues block-aligned prefetches as AXI INCR read bursts, assembles the returned
// beats into a block and reports writeReq / writeResp / invalidate to the data queue.
module prefetch_axi_issuer
    import prefetcher_pkg::*;
#(
    parameter int BA_ADDR_SIZE         = 64,
    parameter int LOG_BLOCK_DATA_BYTES = 6,
    parameter int LOG_AXI_DATA_BYTES   = 3,
    parameter int LOG_MAX_OUTSTANDING  = 3,
    parameter int ID_WIDTH             = 4,
    parameter int PF_ID                = 0
) (
    input  logic                                clk,
    input  logic                                resetN,
    input  logic                                pfReqValid,
    output logic                                pfReqReady,
    input  logic [BA_ADDR_SIZE-1:0]             pfReqAddr,
    input  logic                                queueAlmostFull,
    output logic                                arvalid,
    input  logic                                arready,
    output logic [BA_ADDR_SIZE-1:0]             araddr,
    output logic [7:0]                          arlen,
    output logic [2:0]                          arsize,
    output logic [1:0]                          arburst,
    output logic [ID_WIDTH-1:0]                 arid,
    input  logic                                rvalid,
    output logic                                rready,
    input  logic [(8<<LOG_AXI_DATA_BYTES)-1:0]  rdata,
    input  logic [1:0]                          rresp,
    input  logic                                rlast,
    input  logic [ID_WIDTH-1:0]                 rid,
    output logic                                qOpValid,
    output logic [1:0]                          qOpcode,
    output logic [BA_ADDR_SIZE-1:0]             qAddr,
    output logic [(8<<LOG_BLOCK_DATA_BYTES)-1:0] qData,
    output logic [LOG_MAX_OUTSTANDING:0]        outstandingCnt,
    output logic                                protocolErr
);
    localparam int AXI_W   = 8 << LOG_AXI_DATA_BYTES;
    localparam int BLK_W   = 8 << LOG_BLOCK_DATA_BYTES;
    localparam int LOG_BT  = LOG_BLOCK_DATA_BYTES - LOG_AXI_DATA_BYTES;
    localparam int BEATS   = 1 << LOG_BT;
    localparam int MAX_OUT = 1 << LOG_MAX_OUTSTANDING;
    localparam int CW      = LOG_MAX_OUTSTANDING + 1;
    localparam int BCW     = LOG_BT + 1;
    localparam logic [BA_ADDR_SIZE-1:0] BLK_MASK = {BA_ADDR_SIZE{1'b1}} << LOG_BLOCK_DATA_BYTES;

    ar_state_e               state_q, state_d;
    logic [BA_ADDR_SIZE-1:0] araddr_q, araddr_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [BCW-1:0]          beat_cnt_q, beat_cnt_d, beat_cnt_inc;
    logic                    burst_err_q, burst_err_d, burst_err;
    logic [BLK_W-1:0]        block_q, block_d, block_merged;
    logic                    resp_valid_q, resp_valid_d;
    logic [1:0]              resp_op_q, resp_op_d;
    logic [BA_ADDR_SIZE-1:0] resp_addr_q, resp_addr_d;
    logic [BLK_W-1:0]        resp_data_q, resp_data_d;
    logic                    pending_q, pending_d;
    logic [BA_ADDR_SIZE-1:0] pending_addr_q, pending_addr_d;
    logic                    perr_q, perr_d;
    logic                    req_acc, ar_hs, beat_ok, beat_bad, burst_done, len_bad;
    logic [BA_ADDR_SIZE-1:0] fifo_head;
    logic                    fifo_full, fifo_empty;

    assign pfReqReady = resetN && (state_q == AR_IDLE) && !queueAlmostFull &&
                        (cnt_q < CW'(MAX_OUT)) && !pending_q && !fifo_full;
    assign req_acc    = pfReqValid && pfReqReady;
    assign ar_hs      = arvalid && arready;
    assign rready     = resetN;

    // The FIFO holds exactly the outstanding bursts, so empty means outstandingCnt == 0.
    assign beat_ok      = rvalid && (rid == ID_WIDTH'(PF_ID)) && !fifo_empty;
    assign beat_bad     = rvalid && !beat_ok;
    assign beat_cnt_inc = beat_cnt_q + 1'b1;
    assign burst_done   = beat_ok && (rlast || (beat_cnt_inc == BCW'(BEATS)));
    assign len_bad      = burst_done && !(rlast && (beat_cnt_inc == BCW'(BEATS)));
    assign burst_err    = burst_err_q || (rresp != RESP_OKAY);

    prefetch_addr_fifo #(
        .WIDTH    (BA_ADDR_SIZE),
        .LOG_DEPTH(LOG_MAX_OUTSTANDING)
    ) u_addr_fifo (
        .clk      (clk),
        .resetN   (resetN),
        .push     (ar_hs),
        .push_data(araddr_q),
        .pop      (burst_done),
        .head     (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) state_q <= AR_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            AR_IDLE: if (req_acc) state_d = AR_ADDR;
            AR_ADDR: if (arready) state_d = AR_IDLE;
            default: state_d = AR_IDLE;
        endcase
    end

    always_comb begin
        arvalid = (state_q == AR_ADDR);
        arlen   = arvalid ? 8'(BEATS - 1) : 8'd0;
        arsize  = arvalid ? 3'(LOG_AXI_DATA_BYTES) : 3'd0;
        arburst = arvalid ? BURST_INCR : 2'b00;
        arid    = arvalid ? ID_WIDTH'(PF_ID) : '0;
    end

    // Beat 0 lands at the MSB end of the block.
    always_comb begin
        block_merged = block_q;
        if (beat_ok)
            block_merged[(BEATS - 1 - int'(beat_cnt_q[LOG_BT-1:0])) * AXI_W +: AXI_W] = rdata;
    end

    always_comb begin
        araddr_d       = req_acc ? (pfReqAddr & BLK_MASK) : araddr_q;
        cnt_d          = cnt_q + CW'(ar_hs) - CW'(burst_done);
        beat_cnt_d     = burst_done ? '0 : (beat_ok ? beat_cnt_inc : beat_cnt_q);
        burst_err_d    = burst_done ? 1'b0 : (beat_ok ? burst_err : burst_err_q);
        block_d        = burst_done ? '0 : block_merged;
        perr_d         = perr_q || beat_bad || len_bad;
        resp_valid_d   = burst_done;
        resp_op_d      = OP_INVALIDATE;
        resp_addr_d    = '0;
        resp_data_d    = '0;
        if (burst_done) begin
            resp_addr_d = fifo_head;
            if (!burst_err && !len_bad) begin
                resp_op_d   = OP_WRITE_RESP;
                resp_data_d = block_merged;
            end
        end
        // A writeReq waits here while a response op occupies the output.
        pending_d      = ar_hs || (pending_q && resp_valid_q);
        pending_addr_d = ar_hs ? araddr_q : pending_addr_q;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            araddr_q       <= '0;
            cnt_q          <= '0;
            beat_cnt_q     <= '0;
            burst_err_q    <= 1'b0;
            block_q        <= '0;
            resp_valid_q   <= 1'b0;
            resp_op_q      <= OP_INVALIDATE;
            resp_addr_q    <= '0;
            resp_data_q    <= '0;
            pending_q      <= 1'b0;
            pending_addr_q <= '0;
            perr_q         <= 1'b0;
        end else begin
            araddr_q       <= araddr_d;
            cnt_q          <= cnt_d;
            beat_cnt_q     <= beat_cnt_d;
            burst_err_q    <= burst_err_d;
            block_q        <= block_d;
            resp_valid_q   <= resp_valid_d;
            resp_op_q      <= resp_op_d;
            resp_addr_q    <= resp_addr_d;
            resp_data_q    <= resp_data_d;
            pending_q      <= pending_d;
            pending_addr_q <= pending_addr_d;
            perr_q         <= perr_d;
        end
    end

    always_comb begin
        qOpValid = resp_valid_q || pending_q;
        qOpcode  = OP_INVALIDATE;
        qAddr    = '0;
        qData    = '0;
        if (resp_valid_q) begin
            qOpcode = resp_op_q;
            qAddr   = resp_addr_q;
            qData   = resp_data_q;
        end else if (pending_q) begin
            qOpcode = OP_WRITE_REQ;
            qAddr   = pending_addr_q;
        end
    end

    assign araddr         = araddr_q;
    assign outstandingCnt = cnt_q;
    assign protocolErr    = perr_q;
endmodule
